// File: rtl/mulacc_cfu_arbiter_if.sv
// -----------------------------------------------------------------------------
// mulacc_cfu_arbiter_if
// Bus between the requester arbiter and the shared multiply-accumulate CFU.
//
// Signals
//   cfu_clock_en         arbiter -> CFU  clock enable (held high)
//   cfu_req_valid        arbiter -> CFU  request valid (CFU never stalls)
//   cfu_req_function_id  arbiter -> CFU  0 = reset accumulator, 1 = mulacc
//   cfu_req_id           arbiter -> CFU  {requester index, local id}
//   cfu_req_data         arbiter -> CFU  operand pair {b, a}
//   cfu_resp_valid       CFU -> arbiter  response valid, fixed latency
//   cfu_resp_id          CFU -> arbiter  id echoed from the request
//   cfu_resp_data        CFU -> arbiter  accumulator value
//   cfu_resp_ok          CFU -> arbiter  status
//
// Modports
//   master  arbiter side (drives requests, receives responses)
//   slave   CFU side
// -----------------------------------------------------------------------------
interface mulacc_cfu_arbiter_if #(
   parameter int ID_W          = 6,
   parameter int FUNCTION_ID_W = 1,
   parameter int DATA_W        = 32
) ();

   logic                     cfu_clock_en;
   logic                     cfu_req_valid;
   logic [FUNCTION_ID_W-1:0] cfu_req_function_id;
   logic [ID_W-1:0]          cfu_req_id;
   logic [2*DATA_W-1:0]      cfu_req_data;
   logic                     cfu_resp_valid;
   logic [ID_W-1:0]          cfu_resp_id;
   logic [DATA_W-1:0]        cfu_resp_data;
   logic                     cfu_resp_ok;

   modport master (
      output cfu_clock_en, cfu_req_valid, cfu_req_function_id, cfu_req_id, cfu_req_data,
      input  cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok
   );

   modport slave (
      input  cfu_clock_en, cfu_req_valid, cfu_req_function_id, cfu_req_id, cfu_req_data,
      output cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok
   );

endinterface

// File: rtl/mulacc_cfu_arbiter.sv
// -----------------------------------------------------------------------------
// mulacc_cfu_arbiter
// Shares one pipelined, stateful multiply-accumulate CFU (fixed latency, II=1,
// no backpressure, single accumulator) among NREQ requesters. Round-robin
// arbitration with an optional lock that lets one requester own the
// accumulator across a reset+mulacc sequence. Each issued request carries the
// requester index in the top IDX_W id bits; responses are routed back by it.
//
// Handshake: a requester transfer happens on a rising clock edge where
// rq_valid[i] and rq_ready[i] are both high. rq_ready is combinational and
// may depend on rq_valid in the same cycle; at most one rq_ready bit is high.
// The CFU side is valid-only: requests are always taken, and responses are
// always consumed.
//
// Ports
//   clock, reset      clock; synchronous active-high reset
//   rq_valid/ready    per-requester request handshake
//   rq_lock           requester keeps ownership after this request
//   rq_function_id    packed function ids, requester i at slice i
//   rq_id             packed local ids
//   rq_data           packed operand pairs {b, a}
//   cfu               CFU bus (master modport)
//   rs_valid          per-requester response strobe
//   rs_id/data/ok     shared response payload
//   inflight          issued, not yet returned operations
//   err               sticky protocol error
//   dbg_state         0 = IDLE, 1 = LOCKED
//   dbg_owner         current/last lock owner
//   dbg_rr_ptr        round-robin start index
// -----------------------------------------------------------------------------
module mulacc_cfu_arbiter #(
   parameter int NREQ              = 4,
   parameter int IDX_W             = 2,
   parameter int LOCAL_ID_W        = 4,
   parameter int CFU_FUNCTION_ID_W = 1,
   parameter int CFU_DATA_W        = 32,
   parameter int CFU_LATENCY       = 3,
   parameter int INFLIGHT_W        = $clog2(CFU_LATENCY + 3)
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NREQ-1:0]                       rq_valid,
   output logic [NREQ-1:0]                       rq_ready,
   input  logic [NREQ-1:0]                       rq_lock,
   input  logic [NREQ*CFU_FUNCTION_ID_W-1:0]     rq_function_id,
   input  logic [NREQ*LOCAL_ID_W-1:0]            rq_id,
   input  logic [NREQ*2*CFU_DATA_W-1:0]          rq_data,
   mulacc_cfu_arbiter_if.master                  cfu,
   output logic [NREQ-1:0]                       rs_valid,
   output logic [LOCAL_ID_W-1:0]                 rs_id,
   output logic [CFU_DATA_W-1:0]                 rs_data,
   output logic                                  rs_ok,
   output logic [INFLIGHT_W-1:0]                 inflight,
   output logic                                  err,
   output logic                                  dbg_state,
   output logic [IDX_W-1:0]                      dbg_owner,
   output logic [IDX_W-1:0]                      dbg_rr_ptr
);

   localparam int ID_W    = IDX_W + LOCAL_ID_W;
   localparam int DRAIN_W = (CFU_LATENCY > 1) ? $clog2(CFU_LATENCY + 1) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(CFU_LATENCY);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [0:0]                   state_q, state_d;
   logic [IDX_W-1:0]             owner_q, owner_d;
   logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;

   logic                         req_valid_q;
   logic [CFU_FUNCTION_ID_W-1:0] req_func_q;
   logic [ID_W-1:0]              req_id_q;
   logic [2*CFU_DATA_W-1:0]      req_data_q;

   logic [NREQ-1:0]              rs_valid_q;
   logic [LOCAL_ID_W-1:0]        rs_id_q;
   logic [CFU_DATA_W-1:0]        rs_data_q;
   logic                         rs_ok_q;

   logic [INFLIGHT_W-1:0]        inflight_q, inflight_d;
   logic                         err_q, err_d;
   logic [DRAIN_W-1:0]           drain_q;

   // ---------------------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------------------
   logic                         grant_found;
   logic [IDX_W-1:0]             grant_idx;
   int                           cand;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      if (int'(v) >= NREQ - 1) wrap_inc = '0;
      else                     wrap_inc = v + IDX_W'(1);
   endfunction

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      if (state_q == ST_LOCKED) begin
         grant_idx   = owner_q;
         grant_found = rq_valid[owner_q];
      end else begin
         // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
         for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_found && rq_valid[cand]) begin
               grant_found = 1'b1;
               grant_idx   = IDX_W'(cand);
            end
         end
      end
      // Nothing is accepted while reset is held; it would be lost anyway.
      if (reset) grant_found = 1'b0;
      rq_ready = '0;
      if (grant_found) rq_ready[grant_idx] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // IDLE / LOCKED control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (state_q == ST_IDLE) begin
         if (grant_found) begin
            if (rq_lock[grant_idx]) begin
               state_d = ST_LOCKED;
               owner_d = grant_idx;
            end else begin
               rr_ptr_d = wrap_inc(grant_idx);
            end
         end
      end else begin
         // Release does not wait for a request; a concurrent owner request is
         // accepted as the final one of the locked sequence.
         if (!rq_lock[owner_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_inc(owner_q);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Issue register: payload holds when nothing is accepted.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         req_valid_q <= 1'b0;
         req_func_q  <= '0;
         req_id_q    <= '0;
         req_data_q  <= '0;
      end else begin
         req_valid_q <= grant_found;
         if (grant_found) begin
            req_func_q <= rq_function_id[grant_idx*CFU_FUNCTION_ID_W +: CFU_FUNCTION_ID_W];
            req_id_q   <= {grant_idx, rq_id[grant_idx*LOCAL_ID_W +: LOCAL_ID_W]};
            req_data_q <= rq_data[grant_idx*2*CFU_DATA_W +: 2*CFU_DATA_W];
         end
      end
   end

   assign cfu.cfu_clock_en        = 1'b1;
   assign cfu.cfu_req_valid       = req_valid_q;
   assign cfu.cfu_req_function_id = req_func_q;
   assign cfu.cfu_req_id          = req_id_q;
   assign cfu.cfu_req_data        = req_data_q;

   // ---------------------------------------------------------------------------
   // Response routing
   // ---------------------------------------------------------------------------
   // For CFU_LATENCY cycles after reset the CFU may still return results of
   // operations issued before reset; those are dropped silently.
   logic             resp_take;
   logic [IDX_W-1:0] resp_idx;
   logic             resp_idx_ok;

   assign resp_take   = cfu.cfu_resp_valid && (drain_q == '0);
   assign resp_idx    = cfu.cfu_resp_id[ID_W-1 -: IDX_W];
   assign resp_idx_ok = int'(resp_idx) < NREQ;

   always_ff @(posedge clock) begin
      if (reset) begin
         drain_q <= DRAIN_INIT;
      end else if (drain_q != '0) begin
         drain_q <= drain_q - DRAIN_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rs_valid_q <= '0;
         rs_id_q    <= '0;
         rs_data_q  <= '0;
         rs_ok_q    <= 1'b0;
      end else begin
         rs_valid_q <= '0;
         if (resp_take && resp_idx_ok) begin
            rs_valid_q[resp_idx] <= 1'b1;
            rs_id_q              <= cfu.cfu_resp_id[LOCAL_ID_W-1:0];
            rs_data_q            <= cfu.cfu_resp_data;
            rs_ok_q              <= cfu.cfu_resp_ok;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // In-flight count and sticky error
   // ---------------------------------------------------------------------------
   always_comb begin
      inflight_d = inflight_q;
      // An unexpected response with nothing in flight must not underflow.
      if (req_valid_q && !(resp_take && inflight_q != '0)) begin
         if (!resp_take || inflight_q == '0) inflight_d = inflight_q + INFLIGHT_W'(1);
      end else if (!req_valid_q && resp_take && inflight_q != '0) begin
         inflight_d = inflight_q - INFLIGHT_W'(1);
      end
      err_d = err_q
            | (resp_take && inflight_q == '0)
            | (resp_take && !resp_idx_ok);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign rs_valid   = rs_valid_q;
   assign rs_id      = rs_id_q;
   assign rs_data    = rs_data_q;
   assign rs_ok      = rs_ok_q;
   assign inflight   = inflight_q;
   assign err        = err_q;
   assign dbg_state  = state_q;
   assign dbg_owner  = owner_q;
   assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_mulacc_cfu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mulacc_cfu_arbiter
// Directed bench for mulacc_cfu_arbiter with a behavioural 3-stage CFU
// (single accumulator) attached through the CFU interface.
// -----------------------------------------------------------------------------
module tb_mulacc_cfu_arbiter;

   localparam int NREQ = 4;
   localparam int IDX_W = 2;
   localparam int LW = 4;
   localparam int FW = 1;
   localparam int DW = 32;
   localparam int LAT = 3;
   localparam int IW = 3;
   localparam int ID_W = IDX_W + LW;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [NREQ-1:0]      rq_valid, rq_ready, rq_lock;
   logic [NREQ*FW-1:0]   rq_function_id;
   logic [NREQ*LW-1:0]   rq_id;
   logic [NREQ*2*DW-1:0] rq_data;
   logic [NREQ-1:0]      rs_valid;
   logic [LW-1:0]        rs_id;
   logic [DW-1:0]        rs_data;
   logic                 rs_ok;
   logic [IW-1:0]        inflight;
   logic                 err;
   logic                 dbg_state;
   logic [IDX_W-1:0]     dbg_owner, dbg_rr_ptr;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] exp_q[$];

   mulacc_cfu_arbiter_if #(.ID_W(ID_W), .FUNCTION_ID_W(FW), .DATA_W(DW)) cfu_if ();

   mulacc_cfu_arbiter #(
      .NREQ(NREQ), .IDX_W(IDX_W), .LOCAL_ID_W(LW), .CFU_FUNCTION_ID_W(FW),
      .CFU_DATA_W(DW), .CFU_LATENCY(LAT), .INFLIGHT_W(IW)
   ) dut (
      .clock(clock), .reset(reset),
      .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_lock(rq_lock),
      .rq_function_id(rq_function_id), .rq_id(rq_id), .rq_data(rq_data),
      .cfu(cfu_if),
      .rs_valid(rs_valid), .rs_id(rs_id), .rs_data(rs_data), .rs_ok(rs_ok),
      .inflight(inflight), .err(err),
      .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // ---------------- behavioural CFU ----------------
   logic [2:0]      pv = 3'b000;
   logic [ID_W-1:0] pid [0:2];
   logic [DW-1:0]   pdat [0:2];
   logic [DW-1:0]   acc = '0;
   logic [DW-1:0]   acc_n;

   logic            inj_en = 1'b0;
   logic            inj_valid = 1'b0;
   logic [ID_W-1:0] inj_id = '0;

   always @(posedge clock) begin
      acc_n = acc;
      if (cfu_if.cfu_req_valid) begin
         if (cfu_if.cfu_req_function_id == 1'b0) acc_n = '0;
         else acc_n = acc + cfu_if.cfu_req_data[31:0] * cfu_if.cfu_req_data[63:32];
      end
      acc     <= acc_n;
      pv      <= {pv[1:0], cfu_if.cfu_req_valid};
      pid[0]  <= cfu_if.cfu_req_id;
      pid[1]  <= pid[0];
      pid[2]  <= pid[1];
      pdat[0] <= acc_n;
      pdat[1] <= pdat[0];
      pdat[2] <= pdat[1];
   end

   assign cfu_if.cfu_resp_valid = inj_en ? inj_valid : pv[2];
   assign cfu_if.cfu_resp_id    = inj_en ? inj_id : pid[2];
   assign cfu_if.cfu_resp_data  = inj_en ? 32'hDEAD_BEEF : pdat[2];
   assign cfu_if.cfu_resp_ok    = 1'b1;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      rq_valid = '0;
      rq_lock = '0;
      rq_function_id = '0;
      rq_id = '0;
      rq_data = '0;
   endtask

   task automatic set_lane(input int i, input logic v, input logic lk, input logic f,
                           input logic [LW-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b);
      rq_valid[i] = v;
      rq_lock[i] = lk;
      rq_function_id[i] = f;
      rq_id[i*LW +: LW] = id;
      rq_data[i*2*DW +: 2*DW] = {b, a};
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [127:0] outs;
      do_reset();
      outs = {rq_ready, cfu_if.cfu_req_valid, cfu_if.cfu_req_function_id, cfu_if.cfu_req_id,
              rs_valid, rs_id, rs_ok, inflight, err, dbg_state, dbg_owner, dbg_rr_ptr};
      tests_run++;
      if (outs !== '0) begin tests_failed++; $display("FAIL reset_ctrl: got %0h want 0", outs); end
      tests_run++;
      if (cfu_if.cfu_req_data !== '0) begin tests_failed++; $display("FAIL reset_req_data: got %0h want 0", cfu_if.cfu_req_data); end
      tests_run++;
      if (rs_data !== '0) begin tests_failed++; $display("FAIL reset_rs_data: got %0h want 0", rs_data); end
   endtask

   task automatic test_lock_sequence();
      logic [NREQ-1:0] exp_rv;
      logic [DW-1:0]   exp_d;
      exp_q.delete();
      for (int c = 0; c <= 106; c++) begin
         clear_inputs();
         if (c <= 100) begin
            set_lane(1, 1'b1, (c != 100), (c != 0), LW'(c), 32'd1, 32'(c));
            exp_q.push_back((c == 0) ? 32'd0 : 32'(c * (c + 1) / 2));
         end
         #1;
         if (c <= 100) begin
            tests_run++;
            if (rq_ready !== 4'b0010) begin tests_failed++; $display("FAIL lock_seq_ready c=%0d: got %b want 0010", c, rq_ready); end
         end
         exp_rv = (c >= 5 && c <= 105) ? 4'b0010 : 4'b0000;
         tests_run++;
         if (rs_valid !== exp_rv) begin tests_failed++; $display("FAIL lock_seq_rs_valid c=%0d: got %b want %b", c, rs_valid, exp_rv); end
         if (c >= 5 && c <= 105) begin
            exp_d = exp_q.pop_front();
            tests_run++;
            if (rs_data !== exp_d) begin tests_failed++; $display("FAIL lock_seq_rs_data op=%0d: got %0d want %0d", c - 5, rs_data, exp_d); end
            tests_run++;
            if (rs_id !== LW'(c - 5)) begin tests_failed++; $display("FAIL lock_seq_rs_id op=%0d: got %0d want %0d", c - 5, rs_id, LW'(c - 5)); end
            tests_run++;
            if (rs_ok !== 1'b1) begin tests_failed++; $display("FAIL lock_seq_rs_ok op=%0d: got %b want 1", c - 5, rs_ok); end
         end
         tick();
      end
      tests_run++;
      if (rs_data !== 32'd5050) begin tests_failed++; $display("FAIL lock_seq_final: got %0d want 5050", rs_data); end
      tests_run++;
      if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL lock_seq_state: got %b want 0", dbg_state); end
      tests_run++;
      if (dbg_rr_ptr !== 2'd2) begin tests_failed++; $display("FAIL lock_seq_rr_ptr: got %0d want 2", dbg_rr_ptr); end
      tests_run++;
      if (inflight !== 3'd0) begin tests_failed++; $display("FAIL lock_seq_inflight: got %0d want 0", inflight); end
   endtask

   task automatic test_round_robin();
      logic [LW-1:0]   ids [0:11];
      logic [DW-1:0]   racc;
      logic [DW-1:0]   exp_d;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rv;
      int g;
      int op;
      do_reset();
      exp_q.delete();
      racc = '0;
      for (int c = 0; c < 18; c++) begin
         clear_inputs();
         if (c < 12) begin
            for (int i = 0; i < NREQ; i++)
               set_lane(i, 1'b1, 1'b0, (c != 0), LW'(i + c), 32'(i + 1), 32'(c + 1));
            g = c % NREQ;
            racc = (c == 0) ? 32'd0 : racc + 32'((g + 1) * (c + 1));
            exp_q.push_back(racc);
            ids[c] = LW'(g + c);
         end
         #1;
         if (c < 12) begin
            exp_rdy = 4'(1 << (c % NREQ));
            tests_run++;
            if (rq_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_ready c=%0d: got %b want %b", c, rq_ready, exp_rdy); end
         end
         if (c == 6) begin
            tests_run++;
            if (inflight !== 3'd3) begin tests_failed++; $display("FAIL rr_inflight: got %0d want 3", inflight); end
         end
         op = c - 5;
         exp_rv = (op >= 0 && op < 12) ? 4'(1 << (op % NREQ)) : 4'b0000;
         tests_run++;
         if (rs_valid !== exp_rv) begin tests_failed++; $display("FAIL rr_rs_valid c=%0d: got %b want %b", c, rs_valid, exp_rv); end
         if (op >= 0 && op < 12) begin
            exp_d = exp_q.pop_front();
            tests_run++;
            if (rs_id !== ids[op]) begin tests_failed++; $display("FAIL rr_rs_id op=%0d: got %0d want %0d", op, rs_id, ids[op]); end
            tests_run++;
            if (rs_data !== exp_d) begin tests_failed++; $display("FAIL rr_rs_data op=%0d: got %0d want %0d", op, rs_data, exp_d); end
         end
         tick();
      end
   endtask

   task automatic test_lock_hold();
      logic [NREQ-1:0] exp_rdy;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         set_lane(2, (c <= 5), (c < 5), 1'b1, LW'(c), 32'd1, 32'd1);
         if (c >= 1) begin
            set_lane(0, 1'b1, 1'b0, 1'b1, LW'(c), 32'd1, 32'd1);
            set_lane(3, 1'b1, 1'b0, 1'b1, LW'(c), 32'd1, 32'd1);
         end
         #1;
         exp_rdy = (c <= 5) ? 4'b0100 : (c == 6) ? 4'b1000 : 4'b0001;
         tests_run++;
         if (rq_ready !== exp_rdy) begin tests_failed++; $display("FAIL hold_ready c=%0d: got %b want %b", c, rq_ready, exp_rdy); end
         if (c >= 1 && c <= 5) begin
            tests_run++;
            if ({dbg_state, dbg_owner} !== {1'b1, 2'd2}) begin tests_failed++; $display("FAIL hold_owner c=%0d: got %b/%0d want 1/2", c, dbg_state, dbg_owner); end
         end
         tick();
      end
      clear_inputs();
      for (int n = 0; n < 6; n++) tick();
      tests_run++;
      if (inflight !== 3'd0) begin tests_failed++; $display("FAIL hold_inflight: got %0d want 0", inflight); end
   endtask

   task automatic test_release_idle();
      do_reset();
      set_lane(1, 1'b1, 1'b1, 1'b1, 4'd9, 32'd7, 32'd3);
      #1;
      tests_run++;
      if (rq_ready !== 4'b0010) begin tests_failed++; $display("FAIL rel_first_ready: got %b want 0010", rq_ready); end
      tick();
      set_lane(1, 1'b0, 1'b1, 1'b1, 4'd9, 32'd7, 32'd3);
      #1;
      tests_run++;
      if (rq_ready !== 4'b0000) begin tests_failed++; $display("FAIL rel_idle_ready: got %b want 0000", rq_ready); end
      tests_run++;
      if (dbg_state !== 1'b1) begin tests_failed++; $display("FAIL rel_locked: got %b want 1", dbg_state); end
      tests_run++;
      if ({cfu_if.cfu_req_valid, cfu_if.cfu_req_id} !== {1'b1, 2'd1, 4'd9}) begin
         tests_failed++; $display("FAIL rel_issue: got %b/%0h want 1/19", cfu_if.cfu_req_valid, cfu_if.cfu_req_id);
      end
      tick();
      rq_lock[1] = 1'b0;
      #1;
      tests_run++;
      if (cfu_if.cfu_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rel_no_issue1: got %b want 0", cfu_if.cfu_req_valid); end
      tests_run++;
      if (cfu_if.cfu_req_data !== {32'd3, 32'd7}) begin tests_failed++; $display("FAIL rel_data_hold: got %0h want 300000007", cfu_if.cfu_req_data); end
      tick();
      clear_inputs();
      #1;
      tests_run++;
      if ({dbg_state, dbg_rr_ptr} !== {1'b0, 2'd2}) begin tests_failed++; $display("FAIL rel_idle_state: got %b/%0d want 0/2", dbg_state, dbg_rr_ptr); end
      tests_run++;
      if (cfu_if.cfu_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rel_no_issue2: got %b want 0", cfu_if.cfu_req_valid); end
      for (int n = 0; n < 6; n++) tick();
      tests_run++;
      if ({inflight, err} !== 4'b0000) begin tests_failed++; $display("FAIL rel_drain: got %0d/%b want 0/0", inflight, err); end
   endtask

   task automatic test_reset_inflight();
      logic [127:0] outs;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         set_lane(0, 1'b1, 1'b0, 1'b1, LW'(c), 32'd2, 32'd2);
         tick();
      end
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      outs = {rq_ready, cfu_if.cfu_req_valid, cfu_if.cfu_req_function_id, cfu_if.cfu_req_id,
              rs_valid, rs_id, rs_ok, inflight, err, dbg_state, dbg_owner, dbg_rr_ptr};
      tests_run++;
      if (outs !== '0) begin tests_failed++; $display("FAIL rst_infl_outputs: got %0h want 0", outs); end
      tests_run++;
      if ({cfu_if.cfu_req_data, rs_data} !== '0) begin tests_failed++; $display("FAIL rst_infl_data: got %0h/%0h want 0/0", cfu_if.cfu_req_data, rs_data); end
      for (int n = 0; n < 8; n++) begin
         tests_run++;
         if ({rs_valid, err} !== 5'b0) begin tests_failed++; $display("FAIL rst_infl_late n=%0d: got %b/%b want 0000/0", n, rs_valid, err); end
         tick();
      end
      tests_run++;
      if (inflight !== 3'd0) begin tests_failed++; $display("FAIL rst_infl_count: got %0d want 0", inflight); end
   endtask

   task automatic test_err_sticky();
      do_reset();
      for (int n = 0; n < 4; n++) tick();
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL err_before: got %b want 0", err); end
      inj_en = 1'b1;
      inj_valid = 1'b1;
      inj_id = {2'd1, 4'd5};
      tick();
      inj_valid = 1'b0;
      #1;
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b want 1", err); end
      for (int n = 0; n < 5; n++) tick();
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", err); end
      tests_run++;
      if (inflight !== 3'd0) begin tests_failed++; $display("FAIL err_inflight: got %0d want 0", inflight); end
      inj_en = 1'b0;
      do_reset();
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b want 0", err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clear_inputs();
      test_reset();
      test_lock_sequence();
      test_round_robin();
      test_lock_hold();
      test_release_idle();
      test_reset_inflight();
      test_err_sticky();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mulacc_cfu_arbiter.md
Name: mulacc_cfu_arbiter

Overview:
- Shares one pipelined, stateful multiply-accumulate CFU (fixed latency, II=1, no backpressure, single accumulator) among NREQ requesters.
- Round-robin arbitration, with an optional lock so one requester can own the accumulator across a reset+mulacc sequence.
- Tags each issued request with the requester index in the upper CFU id bits, and routes responses back by that tag.
- Sits between requester cores and the CFU; it drives the CFU with clock_en tied high.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDX_W, 2, requester-index width, clog2(NREQ)
- LOCAL_ID_W, 4, per-requester id width; CFU id width = IDX_W+LOCAL_ID_W
- CFU_FUNCTION_ID_W, 1, function id width (0=reset acc, 1=mulacc)
- CFU_DATA_W, 32, operand/result width
- CFU_LATENCY, 3, fixed CFU request-to-response latency in cycles

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- rq_valid  in  NREQ  per-requester request valid
- rq_ready  out  NREQ  per-requester accept (one-hot or zero)
- rq_lock  in  NREQ  requester wants to retain ownership after this request
- rq_function_id  in  NREQ*CFU_FUNCTION_ID_W  packed, requester i at slice i
- rq_id  in  NREQ*LOCAL_ID_W  packed local request ids
- rq_data  in  NREQ*2*CFU_DATA_W  packed operand pairs {b,a}
- cfu_req_valid  out  1  CFU request valid
- cfu_req_function_id  out  CFU_FUNCTION_ID_W  CFU function
- cfu_req_id  out  IDX_W+LOCAL_ID_W  {index, local id}
- cfu_req_data  out  2*CFU_DATA_W  operands
- cfu_resp_valid  in  1  CFU response valid
- cfu_resp_id  in  IDX_W+LOCAL_ID_W  CFU response id
- cfu_resp_data  in  CFU_DATA_W  accumulator value
- cfu_resp_ok  in  1  CFU status
- rs_valid  out  NREQ  per-requester response valid
- rs_id  out  LOCAL_ID_W  local id of the response (shared)
- rs_data  out  CFU_DATA_W  response data (shared)
- rs_ok  out  1  response status (shared)
- inflight  out  clog2(CFU_LATENCY+3)  count of issued, not yet returned ops
- err  out  1  sticky protocol error

Behaviour:
- Reset: every output is 0; state=IDLE, owner=0, rr_ptr=0, inflight=0, err=0. In-flight CFU results arriving after reset are discarded (rs_valid stays 0); they do not set err.
- States: IDLE and LOCKED(owner).
- IDLE grant: the first i with rq_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ. rq_ready[i]=1 for that i only, combinationally in the same cycle.
- LOCKED grant: rq_ready[owner]=rq_valid[owner]; every other requester gets rq_ready=0.
- Accept at IDLE with rq_lock=1: go to LOCKED, owner=i.
- Accept at IDLE with rq_lock=0: stay in IDLE, rr_ptr=i+1 (wraps at NREQ).
- LOCKED release: any cycle with rq_lock[owner]=0, whether or not owner is valid. If owner is valid that cycle, its request is accepted as the final one. Next state IDLE, rr_ptr=owner+1.
- Issue: the accepted request is registered. Next cycle, cfu_req_valid=1 with function, data, and id={i, rq_id_i}. Otherwise cfu_req_valid=0 and data fields hold their values. Sustains one accept per cycle.
- Response: registered one cycle. rs_valid[cfu_resp_id[top IDX_W]]=1; rs_id, rs_data and rs_ok come from the CFU.
- End-to-end latency: accept at cycle t, rs_valid at t+CFU_LATENCY+2.
- inflight: +1 on cfu_req_valid, -1 on cfu_resp_valid, net 0 when both occur.
- err is set, and stays set until reset, on either of:
  - cfu_resp_valid while inflight==0
  - response index >= NREQ; that response is dropped
- Function 0 from a non-owner in IDLE is legal and resets the shared accumulator. Software locks around reset+mulacc sequences.

Test Plan:
- Single requester 1, lock=1: reset op, then mulacc of (1,k) for k=1..100, lock deasserted on k=100 -> rs_valid[1] on each op; final rs_data=5050; state returns to IDLE with rr_ptr=2.
- All four requesters valid continuously, lock=0 -> grants 0,1,2,3,0,... one per cycle; each rs_valid arrives exactly 5 cycles after its accept with the matching rs_id.
- Requester 2 holds the lock while 0 and 3 are valid -> rq_ready[0] and rq_ready[3] stay 0 until release. Next grant goes to 3, then 0.
- Owner drops rq_lock while rq_valid=0 -> IDLE the next cycle; no spurious issue.
- Reset asserted with 3 ops in flight -> all outputs 0; the late CFU responses produce no rs_valid and err=0.
- Inject cfu_resp_valid with inflight==0 -> err=1 and stays 1 until reset.
